flag_unit: RTL and testbench
============================

Name: flag_unit

Overview:
- Producer side of the condition-flag interface: derives NZCV from the ALU result and holds it in the architectural status register.
- Presents the stored flags to the condition checker and receives its CondEx verdict back.
- Uses CondEx to gate the instruction's write controls and register them into the next pipeline stage.
- Sits between the ALU/decoder and the writeback/fetch control in the single-issue processor.

Parameters:
- WIDTH, 32, ALU result width in bits (minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  an instruction is present this cycle.
- stall  input  1  hold all state; no flag or pipeline update.
- flush  input  1  squash the instruction entering the output register.
- cond  input  4  instruction condition field; 4'b1111 is illegal.
- alu_result  input  WIDTH  ALU result.
- alu_carry  input  1  ALU carry out.
- alu_ovf  input  1  ALU signed overflow.
- flag_w  input  2  flag write enables: [1] updates N,Z; [0] updates C,V.
- reg_write  input  1  ungated register-write request.
- mem_write  input  1  ungated memory-write request.
- pc_src  input  1  ungated branch/PC-write request.
- cond_ex  input  1  verdict returned by the condition checker.
- ALUflags  output  4  stored flags to the checker: [3]=N, [2]=Z, [1]=C, [0]=V.
- reg_write_q  output  1  registered, gated register write.
- mem_write_q  output  1  registered, gated memory write.
- pc_src_q  output  1  registered, gated PC write.
- valid_q  output  1  output-stage valid.
- illegal_q  output  1  registered pulse: an illegal condition was seen.

Behaviour:
- Reset (asynchronous on rst_n low): ALUflags=4'b0000; all *_q outputs 0. Takes effect immediately, including mid-stall. Registers resume updating on the first rising edge after rst_n goes high.
- Flag generation (combinational):
  - n_new = alu_result[WIDTH-1].
  - z_new = (alu_result == 0), all WIDTH bits compared.
  - c_new = alu_carry.
  - v_new = alu_ovf.
- Execute qualifier: exec = in_valid & cond_ex & ~illegal & ~stall, where illegal = in_valid & (cond==4'b1111).
- Flag register update at the rising edge when exec=1:
  - flag_w[1] loads N,Z.
  - flag_w[0] loads C,V.
  - Any half not enabled keeps its old value.
  - flag_w=2'b00 leaves all flags unchanged.
- ALUflags is driven only from the register, never bypassed. An instruction is evaluated against flags set by earlier instructions, never its own. A flag write becomes visible to cond_ex one cycle later.
- Flags are not written when cond_ex=0. A failed-condition instruction has no architectural effect.
- Gating (combinational): g_x = x & exec, for x in {reg_write, mem_write, pc_src}.
- Output register, updated at the rising edge with latency 1:
  - stall=1: all *_q hold.
  - else flush=1: all *_q load 0. The flags still update if exec=1, because flush squashes only the downstream stage.
  - else: valid_q <= in_valid; reg_write_q/mem_write_q/pc_src_q <= g_x; illegal_q <= illegal.
- Simultaneous stall and flush: stall wins; everything holds.
- Illegal condition: all gated controls are forced 0 and the flags are unchanged, regardless of cond_ex. illegal_q pulses high for one cycle unless stalled or flushed.
- in_valid=0: no flag update; valid_q=0 and gated outputs 0 next cycle.
- Flag update plus gated outputs: 120-200 lines of RTL expected.

Test Plan:
- Reset mid-operation: assert rst_n=0 asynchronously while ALUflags=4'b1010 -> ALUflags=0000 and all *_q=0 immediately, before any clock edge.
- SUBS, Z update:
  - Stimulus: WIDTH=32, cond=1110, cond_ex=1, alu_result=0, carry=1, ovf=0, flag_w=11.
  - Next cycle: ALUflags=4'b0110.
  - Following instruction with cond=0000: checker returns cond_ex=1 and reg_write_q=1 one cycle later.
- Partial write:
  - Flags start at 4'b0011.
  - Stimulus: alu_result=32'h8000_0000, flag_w=10, exec=1.
  - Result: ALUflags=4'b1011, with C,V retained.
- Failed condition:
  - Stimulus: cond_ex=0, flag_w=11, reg_write=mem_write=pc_src=1.
  - Result: flags unchanged; next cycle valid_q=1 and all gated outputs 0.
- Illegal cond=1111 with cond_ex=1, reg_write=1 -> reg_write_q=0, illegal_q=1 for exactly one cycle, flags unchanged.
- Stall and flush ordering:
  - stall=1 for 2 cycles with exec-qualifying inputs: *_q and ALUflags hold.
  - Then stall=0, flush=1: outputs 0, flags updated once.
  - stall=1 and flush=1 together: everything holds.

Source files
------------

// File: rtl/flag_unit.sv
// flag_unit: condition-flag producer and write-control gating stage.
// Derives NZCV from the ALU result, holds them in the status register,
// presents them to the condition checker and uses the returned verdict
// (cond_ex) to gate the instruction's write controls into the next stage.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid            instruction present this cycle
//   stall               hold all state (flags and output stage)
//   flush               squash the instruction entering the output stage
//   cond                condition field, 4'b1111 is illegal
//   alu_result          ALU result (WIDTH bits)
//   alu_carry, alu_ovf  ALU carry out / signed overflow
//   flag_w              [1] loads N,Z  [0] loads C,V
//   reg_write, mem_write, pc_src   ungated write requests
//   cond_ex             condition checker verdict
//   ALUflags            stored flags {N,Z,C,V}
//   reg_write_q, mem_write_q, pc_src_q   registered gated controls
//   valid_q             output-stage valid
//   illegal_q           registered illegal-condition pulse
module flag_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       cond,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic [1:0]       flag_w,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             pc_src,
  input  logic             cond_ex,
  output logic [3:0]       ALUflags,
  output logic             reg_write_q,
  output logic             mem_write_q,
  output logic             pc_src_q,
  output logic             valid_q,
  output logic             illegal_q
);

  localparam logic [3:0] COND_ILLEGAL = 4'b1111;

  logic [3:0] r_flags;
  logic       r_valid_q;
  logic       r_reg_write_q;
  logic       r_mem_write_q;
  logic       r_pc_src_q;
  logic       r_illegal_q;

  logic       w_n_new;
  logic       w_z_new;
  logic       w_illegal;
  logic       w_exec;
  logic       w_g_reg_write;
  logic       w_g_mem_write;
  logic       w_g_pc_src;

  // New flag values from the current ALU result.
  always_comb begin
    w_n_new = alu_result[WIDTH-1];
    w_z_new = (alu_result == '0);
  end

  // Execute qualifier and gated write controls.
  always_comb begin
    w_illegal     = in_valid & (cond == COND_ILLEGAL);
    w_exec        = in_valid & cond_ex & ~w_illegal & ~stall;
    w_g_reg_write = reg_write & w_exec;
    w_g_mem_write = mem_write & w_exec;
    w_g_pc_src    = pc_src    & w_exec;
  end

  // Status register; each half written independently. Flush does not block
  // this update since it only squashes the downstream stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (w_exec) begin
      if (flag_w[1]) r_flags[3:2] <= {w_n_new, w_z_new};
      if (flag_w[0]) r_flags[1:0] <= {alu_carry, alu_ovf};
    end
  end

  // Output stage: stall holds (and wins over flush), flush clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q     <= 1'b0;
      r_reg_write_q <= 1'b0;
      r_mem_write_q <= 1'b0;
      r_pc_src_q    <= 1'b0;
      r_illegal_q   <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        r_valid_q     <= 1'b0;
        r_reg_write_q <= 1'b0;
        r_mem_write_q <= 1'b0;
        r_pc_src_q    <= 1'b0;
        r_illegal_q   <= 1'b0;
      end else begin
        r_valid_q     <= in_valid;
        r_reg_write_q <= w_g_reg_write;
        r_mem_write_q <= w_g_mem_write;
        r_pc_src_q    <= w_g_pc_src;
        r_illegal_q   <= w_illegal;
      end
    end
  end

  // Flags are presented straight from the register, never bypassed.
  always_comb begin
    ALUflags    = r_flags;
    valid_q     = r_valid_q;
    reg_write_q = r_reg_write_q;
    mem_write_q = r_mem_write_q;
    pc_src_q    = r_pc_src_q;
    illegal_q   = r_illegal_q;
  end

endmodule

// File: tb/tb_flag_unit.sv
// Testbench for flag_unit: directed vectors with literal expectations plus
// a per-cycle comparison against a behavioural model of the flag stage.
module tb_flag_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, stall, flush;
  logic [3:0]       cond;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry, alu_ovf;
  logic [1:0]       flag_w;
  logic             reg_write, mem_write, pc_src;
  logic             cond_ex;
  logic             cond_ex_drv, use_chk;
  logic [3:0]       ALUflags;
  logic             reg_write_q, mem_write_q, pc_src_q, valid_q, illegal_q;

  int n_checks = 0;
  int n_errors = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  flag_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .cond(cond), .alu_result(alu_result), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .flag_w(flag_w), .reg_write(reg_write), .mem_write(mem_write), .pc_src(pc_src),
    .cond_ex(cond_ex), .ALUflags(ALUflags), .reg_write_q(reg_write_q),
    .mem_write_q(mem_write_q), .pc_src_q(pc_src_q), .valid_q(valid_q),
    .illegal_q(illegal_q)
  );

  // Condition checker stand-in (ARM condition codes) evaluated on stored flags.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b1;
    endcase
  endfunction

  assign cond_ex = use_chk ? cond_pass(cond, ALUflags) : cond_ex_drv;

  // Behavioural model: architectural flags and the expected output stage.
  logic [3:0] m_flags;
  logic       m_valid, m_rw, m_mw, m_ps, m_ill;
  logic       m_is_ill, m_go;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flags = 4'b0000;
      {m_valid, m_rw, m_mw, m_ps, m_ill} = 5'b0;
    end else begin
      m_is_ill = in_valid && (cond == 4'hF);
      m_go     = in_valid && cond_ex && !m_is_ill && !stall;
      if (!stall) begin
        if (flush) begin
          {m_valid, m_rw, m_mw, m_ps, m_ill} = 5'b0;
        end else begin
          m_valid = in_valid;
          m_rw    = m_go && reg_write;
          m_mw    = m_go && mem_write;
          m_ps    = m_go && pc_src;
          m_ill   = m_is_ill;
        end
      end
      if (m_go && flag_w[1]) begin
        m_flags[3] = alu_result[WIDTH-1];
        m_flags[2] = (alu_result == 0);
      end
      if (m_go && flag_w[0]) begin
        m_flags[1] = alu_carry;
        m_flags[0] = alu_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      n_checks++;
      if ({ALUflags, valid_q, reg_write_q, mem_write_q, pc_src_q, illegal_q} !==
          {m_flags, m_valid, m_rw, m_mw, m_ps, m_ill}) begin
        n_errors++;
        $display("FAIL model_cmp t=%0t got flags=%b v/rw/mw/pc/ill=%b%b%b%b%b want flags=%b v/rw/mw/pc/ill=%b%b%b%b%b",
                 $time, ALUflags, valid_q, reg_write_q, mem_write_q, pc_src_q, illegal_q,
                 m_flags, m_valid, m_rw, m_mw, m_ps, m_ill);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Apply one instruction, then wait until just after the next rising edge.
  task automatic drive(input logic v, input logic st, input logic fl, input logic [3:0] c,
                       input logic ce, input logic uc, input logic [WIDTH-1:0] r,
                       input logic ca, input logic ov, input logic [1:0] fw,
                       input logic rw, input logic mw, input logic ps);
    in_valid = v; stall = st; flush = fl; cond = c; cond_ex_drv = ce; use_chk = uc;
    alu_result = r; alu_carry = ca; alu_ovf = ov; flag_w = fw;
    reg_write = rw; mem_write = mw; pc_src = ps;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 4'hE, 1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [8:0] outs();
    return {ALUflags, valid_q, reg_write_q, mem_write_q, pc_src_q, illegal_q};
  endfunction

  initial begin
    rst_n = 1'b1;
    in_valid = 0; stall = 0; flush = 0; cond = 4'hE; cond_ex_drv = 0; use_chk = 0;
    alu_result = '0; alu_carry = 0; alu_ovf = 0; flag_w = 2'b00;
    reg_write = 0; mem_write = 0; pc_src = 0;
    #1 rst_n = 1'b0;
    #20;
    chk("reset_initial", 32'(outs()), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    started = 1'b1;

    // Flags to 1010, then asynchronous reset between edges.
    drive(1, 0, 0, 4'hE, 1, 0, 32'h8000_0000, 1, 0, 2'b11, 1, 0, 0);
    chk("flags_1010", 32'(ALUflags), 32'hA);
    chk("valid_before_rst", 32'(valid_q), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("reset_midop", 32'(outs()), 32'h0);
    #1 rst_n = 1'b1;

    // SUBS producing zero, then EQ evaluated through the checker.
    drive(1, 0, 0, 4'hE, 1, 0, 32'h0, 1, 0, 2'b11, 0, 0, 0);
    chk("subs_flags", 32'(ALUflags), 32'h6);
    drive(1, 0, 0, 4'h0, 0, 1, 32'h5, 0, 0, 2'b00, 1, 0, 0);
    chk("eq_reg_write_q", 32'(reg_write_q), 32'h1);

    // Partial write: only N,Z load.
    drive(1, 0, 0, 4'hE, 1, 0, 32'h1, 1, 1, 2'b11, 0, 0, 0);
    chk("flags_0011", 32'(ALUflags), 32'h3);
    drive(1, 0, 0, 4'hE, 1, 0, 32'h8000_0000, 0, 0, 2'b10, 0, 0, 0);
    chk("partial_nz", 32'(ALUflags), 32'hB);

    // Failed condition: no architectural effect.
    drive(1, 0, 0, 4'h0, 0, 0, 32'h0, 0, 0, 2'b11, 1, 1, 1);
    chk("fail_cond_flags", 32'(ALUflags), 32'hB);
    chk("fail_cond_outs", 32'({valid_q, reg_write_q, mem_write_q, pc_src_q}), 32'h8);

    // Illegal condition pulses illegal_q once.
    drive(1, 0, 0, 4'hF, 1, 0, 32'h0, 0, 0, 2'b11, 1, 0, 0);
    chk("illegal_rw", 32'(reg_write_q), 32'h0);
    chk("illegal_q_hi", 32'(illegal_q), 32'h1);
    chk("illegal_flags", 32'(ALUflags), 32'hB);
    idle();
    chk("illegal_q_lo", 32'(illegal_q), 32'h0);
    chk("idle_valid", 32'(valid_q), 32'h0);

    // Stall holds everything; flush clears outputs but flags update.
    drive(1, 0, 0, 4'hE, 1, 0, 32'h7, 0, 0, 2'b00, 1, 0, 0);
    chk("pre_stall_outs", 32'({valid_q, reg_write_q, mem_write_q}), 32'h6);
    drive(1, 1, 0, 4'hE, 1, 0, 32'h0, 0, 1, 2'b11, 1, 1, 0);
    drive(1, 1, 0, 4'hE, 1, 0, 32'h0, 0, 1, 2'b11, 1, 1, 0);
    chk("stall_outs", 32'({valid_q, reg_write_q, mem_write_q}), 32'h6);
    chk("stall_flags", 32'(ALUflags), 32'hB);
    drive(1, 0, 1, 4'hE, 1, 0, 32'h0, 0, 1, 2'b11, 1, 1, 0);
    chk("flush_outs", 32'({valid_q, reg_write_q, mem_write_q}), 32'h0);
    chk("flush_flags", 32'(ALUflags), 32'h5);
    drive(1, 0, 0, 4'hE, 1, 0, 32'h3, 0, 0, 2'b00, 0, 1, 0);
    chk("pre_both_outs", 32'({valid_q, mem_write_q}), 32'h3);
    drive(1, 1, 1, 4'hE, 1, 0, 32'h1, 1, 1, 2'b11, 1, 0, 1);
    chk("stall_flush_outs", 32'({valid_q, reg_write_q, mem_write_q, pc_src_q}), 32'hA);
    chk("stall_flush_flags", 32'(ALUflags), 32'h5);

    // Pseudo-random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
      drive(($urandom_range(0, 4) != 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 6) == 0),
            4'($urandom), 1'($urandom), 1'($urandom), r, 1'($urandom), 1'($urandom),
            2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
